uart_param: RTL and testbench
=============================

UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter CLK_FREQ, default 20000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 100000, line bit rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal values 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, stop bits: 1 or 2.
REQ-006 Port clk_in, input, 1, single clock; all logic rising-edge.
REQ-007 Port rst_in, input, 1, reset; synchronous, active-high.
REQ-008 Port data_in, input, DATA_BITS, transmit word.
REQ-009 Port send_in, input, 1, transmit request strobe.
REQ-010 Port tx_ready_out, output, 1, high when the transmitter accepts a word.
REQ-011 Port txd_out, output, 1, serial transmit line, idle high.
REQ-012 Port rxd_in, input, 1, asynchronous serial receive line.
REQ-013 Port data_out, output, DATA_BITS, last received word, held until the next word completes.
REQ-014 Port rx_ready_out, output, 1, one-cycle pulse when data_out updates.
REQ-015 Port rx_frame_err_out, output, 1, frame-error flag, valid with rx_ready_out.
REQ-016 Port rx_parity_err_out, output, 1, parity-error flag, valid with rx_ready_out; always 0 when PARITY=0.

Function
REQ-017 Tick generator SHALL produce a one-cycle tick every DIV clocks, DIV = (CLK_FREQ + 8*BAUD_RATE) / (16*BAUD_RATE), integer division (default 13); 16 ticks = 1 bit.
REQ-018 TX and RX SHALL share the tick; each keeps its own 4-bit tick phase counter.
REQ-019 TX frame: start bit 0, DATA_BITS bits LSB first, optional parity bit, STOP_BITS stop bits of 1.
REQ-020 Parity bit = XOR of the data bits (even mode); inverted (odd mode).
REQ-021 TX FSM states: IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-022 send_in with tx_ready_out=1 SHALL latch data_in that cycle; tx_ready_out falls the next cycle; send_in while busy SHALL be ignored.
REQ-023 Start bit SHALL begin on the first tick after the latch; each bit lasts exactly 16 ticks.
REQ-024 tx_ready_out SHALL rise on the cycle after the last stop bit's 16th tick; back-to-back sends add no idle gap.
REQ-025 rxd_in SHALL pass through a 2-flop synchroniser before any use.
REQ-026 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-027 IDLE->START on the synchronised falling edge; RX phase resets to 0.
REQ-028 Every bit SHALL be decided by majority vote of the samples at phase 7, 8 and 9.
REQ-029 Start bit voted 1 SHALL return the FSM to IDLE (glitch reject) with no pulse and no flags.
REQ-030 Only the first stop bit is checked; stop bit voted 0 SHALL set rx_frame_err_out.
REQ-031 Decision point: phase 9 of the first stop bit. That cycle SHALL set data_out, both error flags and a one-cycle rx_ready_out, even on error.
REQ-032 After the decision point, RX SHALL wait for rxd high before IDLE; a break (line held low) yields exactly one pulse.
REQ-033 Error flags SHALL hold until the next rx_ready_out.
REQ-034 TX and RX SHALL run fully independently; simultaneous activity is legal.

Reset
REQ-035 rst_in high at a clock edge SHALL, that edge: set both FSMs to IDLE, clear tick divider and phase counters, set txd_out=1 and tx_ready_out=1, clear data_out, rx_ready_out, rx_frame_err_out and rx_parity_err_out to 0, and set the synchroniser flops to 1.
REQ-036 Reset mid-frame SHALL abort the frame with no rx_ready_out pulse; txd_out returns high on the same edge.

Verification
REQ-037 Defaults, send 0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1; each bit 208 clocks; tx_ready_out back after 2080 clocks +/-13.
REQ-038 Loopback txd->rxd with PARITY=1, DATA_BITS=7, STOP_BITS=2, send 0x55 -> one rx_ready_out pulse, data_out=0x55, both error flags 0.
REQ-039 PARITY=2; inject frame 0x0F with even parity -> data_out=0x0F and rx_parity_err_out=1.
REQ-040 Inject 0x3C with stop bit 0, then line held low 30 bit times -> exactly one pulse, rx_frame_err_out=1; the next clean 0x81 -> frame error clears.
REQ-041 Glitch: rxd low 3 ticks -> no pulse, RX FSM in IDLE; a 1-tick glitch inside data bit 3 of 0xFF -> data_out=0xFF.
REQ-042 Assert rst_in during data bit 4 of both TX and RX -> txd_out=1 and tx_ready_out=1 next cycle; no rx_ready_out pulse; a following frame is received correctly.

Source files
------------

// File: rtl/uart_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_param : UART with shared 16x oversampling tick, configurable frame.  |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module uart_param #(
  parameter int CLK_FREQ  = 20000000,
  parameter int BAUD_RATE = 100000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send_in,
  output logic                 tx_ready_out,
  output logic                 txd_out,
  input  logic                 rxd_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_ready_out,
  output logic                 rx_frame_err_out,
  output logic                 rx_parity_err_out
);

  localparam int   DIV   = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int   DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  state_t                tx_state_q, tx_state_d;
  logic [3:0]            tx_phase_q, tx_phase_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_stop_q, tx_stop_d;
  logic                  tx_pend_q, tx_pend_d;
  logic                  txd_q, txd_d;

  logic [1:0]            sync_q, sync_d;
  logic                  rx_prev_q, rx_s, vote;
  state_t                rx_state_q, rx_state_d;
  logic [3:0]            rx_phase_q, rx_phase_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic [1:0]            rx_smp_q, rx_smp_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_done_q, rx_done_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  frame_err_q, frame_err_d;
  logic                  par_err_q, par_err_d;

  assign tick   = (div_q == DIV_W'(DIV - 1));
  assign div_d  = tick ? '0 : div_q + 1'b1;
  assign sync_d = {sync_q[0], rxd_in};
  assign rx_s   = sync_q[1];
  assign vote   = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s) | (rx_smp_q[1] & rx_s);

  assign tx_ready_out      = (tx_state_q == S_IDLE) && !tx_pend_q;
  assign txd_out           = txd_q;
  assign data_out          = data_q;
  assign rx_ready_out      = rx_ready_q;
  assign rx_frame_err_out  = frame_err_q;
  assign rx_parity_err_out = par_err_q;

  // A latched word waits in IDLE (pend) until the next tick so the start bit is a full 16 ticks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_phase_d = tx_phase_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_pend_d  = tx_pend_q;
    txd_d      = txd_q;
    case (tx_state_q)
      S_IDLE: begin
        if (send_in && tx_ready_out) begin
          tx_shift_d = data_in;
          tx_par_d   = (^data_in) ^ ODD;
          tx_pend_d  = 1'b1;
        end
        if (tx_pend_q && tick) begin
          tx_state_d = S_START;
          tx_phase_d = 4'd0;
          tx_pend_d  = 1'b0;
          txd_d      = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          if (tx_phase_q != 4'd15) begin
            tx_phase_d = tx_phase_q + 4'd1;
          end else begin
            tx_phase_d = 4'd0;
            case (tx_state_q)
              S_START: begin
                tx_state_d = S_DATA;
                tx_bit_d   = 4'd0;
                txd_d      = tx_shift_q[0];
              end
              S_DATA: begin
                if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                  tx_stop_d = 1'b0;
                  if (PARITY != 0) begin
                    tx_state_d = S_PARITY;
                    txd_d      = tx_par_q;
                  end else begin
                    tx_state_d = S_STOP;
                    txd_d      = 1'b1;
                  end
                end else begin
                  tx_bit_d   = tx_bit_q + 4'd1;
                  tx_shift_d = tx_shift_q >> 1;
                  txd_d      = tx_shift_q[1];
                end
              end
              S_PARITY: begin
                tx_state_d = S_STOP;
                txd_d      = 1'b1;
              end
              default: begin
                if (STOP_BITS == 2 && !tx_stop_q) begin
                  tx_stop_d = 1'b1;
                end else begin
                  tx_state_d = S_IDLE;
                  txd_d      = 1'b1;
                end
              end
            endcase
          end
        end
      end
    endcase
  end

  // Bits are decided at phase 9 from the phase 7/8/9 samples; rx_done blocks repeat pulses on a break.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_phase_d  = rx_phase_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_smp_d    = rx_smp_q;
    rx_perr_d   = rx_perr_q;
    rx_done_d   = rx_done_q;
    data_d      = data_q;
    rx_ready_d  = 1'b0;
    frame_err_d = frame_err_q;
    par_err_d   = par_err_q;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = S_START;
          rx_phase_d = 4'd0;
          rx_done_d  = 1'b0;
          rx_perr_d  = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          rx_phase_d = rx_phase_q + 4'd1;
          if (rx_phase_q == 4'd7) rx_smp_d[0] = rx_s;
          if (rx_phase_q == 4'd8) rx_smp_d[1] = rx_s;
          if (rx_phase_q == 4'd9) begin
            case (rx_state_q)
              S_START:  if (vote) rx_state_d = S_IDLE;
              S_DATA:   rx_shift_d = {vote, rx_shift_q[DATA_BITS-1:1]};
              S_PARITY: rx_perr_d = vote ^ (^rx_shift_q) ^ ODD;
              S_STOP: begin
                if (!rx_done_q) begin
                  data_d      = rx_shift_q;
                  frame_err_d = !vote;
                  par_err_d   = (PARITY != 0) ? rx_perr_q : 1'b0;
                  rx_ready_d  = 1'b1;
                  rx_done_d   = 1'b1;
                end
              end
              default: ;
            endcase
          end
          if (rx_phase_q == 4'd15) begin
            case (rx_state_q)
              S_START: begin
                rx_state_d = S_DATA;
                rx_bit_d   = 4'd0;
              end
              S_DATA: begin
                if (rx_bit_q == 4'(DATA_BITS - 1)) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                else rx_bit_d = rx_bit_q + 4'd1;
              end
              S_PARITY: rx_state_d = S_STOP;
              default: ;
            endcase
          end
        end
        if (rx_state_q == S_STOP && rx_done_q && rx_s) rx_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q       <= '0;
      tx_state_q  <= S_IDLE;
      tx_phase_q  <= 4'd0;
      tx_bit_q    <= 4'd0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_stop_q   <= 1'b0;
      tx_pend_q   <= 1'b0;
      txd_q       <= 1'b1;
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_phase_q  <= 4'd0;
      rx_bit_q    <= 4'd0;
      rx_shift_q  <= '0;
      rx_smp_q    <= 2'b11;
      rx_perr_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      data_q      <= '0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      tx_state_q  <= tx_state_d;
      tx_phase_q  <= tx_phase_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_stop_q   <= tx_stop_d;
      tx_pend_q   <= tx_pend_d;
      txd_q       <= txd_d;
      sync_q      <= sync_d;
      rx_prev_q   <= rx_s;
      rx_state_q  <= rx_state_d;
      rx_phase_q  <= rx_phase_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_smp_q    <= rx_smp_d;
      rx_perr_q   <= rx_perr_d;
      rx_done_q   <= rx_done_d;
      data_q      <= data_d;
      rx_ready_q  <= rx_ready_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_param : directed bench for uart_param in three configurations.   |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_uart_param;

  localparam int BIT = 208;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] data_a;
  logic       send_a, rdy_a, txd_a, rxd_a, rxr_a, fe_a, pe_a;
  logic [7:0] dout_a;
  logic [6:0] data_b, dout_b;
  logic       send_b, rdy_b, txd_b, rxr_b, fe_b, pe_b;
  logic [7:0] data_o, dout_o;
  logic       send_o, rdy_o, txd_o, rxd_o, rxr_o, fe_o, pe_o;

  uart_param u_def (
    .clk_in(clk), .rst_in(rst), .data_in(data_a), .send_in(send_a),
    .tx_ready_out(rdy_a), .txd_out(txd_a), .rxd_in(rxd_a), .data_out(dout_a),
    .rx_ready_out(rxr_a), .rx_frame_err_out(fe_a), .rx_parity_err_out(pe_a)
  );

  uart_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_e72 (
    .clk_in(clk), .rst_in(rst), .data_in(data_b), .send_in(send_b),
    .tx_ready_out(rdy_b), .txd_out(txd_b), .rxd_in(txd_b), .data_out(dout_b),
    .rx_ready_out(rxr_b), .rx_frame_err_out(fe_b), .rx_parity_err_out(pe_b)
  );

  uart_param #(.PARITY(2)) u_odd (
    .clk_in(clk), .rst_in(rst), .data_in(data_o), .send_in(send_o),
    .tx_ready_out(rdy_o), .txd_out(txd_o), .rxd_in(rxd_o), .data_out(dout_o),
    .rx_ready_out(rxr_o), .rx_frame_err_out(fe_o), .rx_parity_err_out(pe_o)
  );

  int pa = 0, pb = 0, po = 0;
  always @(posedge clk) begin
    if (rxr_a) pa++;
    if (rxr_b) pb++;
    if (rxr_o) po++;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel 0 drives u_def's receive line, anything else drives u_odd's.
  task automatic drive(input int sel, input logic v, input int n);
    if (sel == 0) rxd_a = v;
    else rxd_o = v;
    cycles(n);
  endtask

  task automatic frame(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) drive(sel, bits[i], BIT);
  endtask

  initial begin
    int         c0, t0, d, k, base;
    logic [9:0] exp_tx;
    logic [7:0] rv;
    data_a = 8'h00; send_a = 1'b0; rxd_a = 1'b1;
    data_b = 7'h00; send_b = 1'b0;
    data_o = 8'h00; send_o = 1'b0; rxd_o = 1'b1;

    rst = 1'b1;
    cycles(3);
    chk("reset txd", txd_a, 1);
    chk("reset tx_ready", rdy_a, 1);
    chk("reset data_out", dout_a, 0);
    chk("reset rx_ready", rxr_a, 0);
    chk("reset frame_err", fe_a, 0);
    chk("reset parity_err", pe_a, 0);
    chk("reset odd txd", txd_o, 1);
    chk("reset odd tx_ready", rdy_o, 1);
    rst = 1'b0;
    cycles(2);

    // 8N1 transmit of 0xA5, with a send attempt while busy that must be ignored
    data_a = 8'hA5; send_a = 1'b1; c0 = cyc;
    cycles(1);
    send_a = 1'b0;
    chk("tx_ready falls after latch", rdy_a, 0);
    k = 0;
    while (txd_a && k < 20) begin cycles(1); k++; end
    chk("tx start bit", txd_a, 0);
    t0 = cyc;
    data_a = 8'h00; send_a = 1'b1;
    cycles(1);
    send_a = 1'b0;
    k = 0;
    while (!txd_a && k < 300) begin cycles(1); k++; end
    chk("tx start bit length", cyc - t0, BIT);
    exp_tx = {1'b1, 8'hA5, 1'b0};
    for (int i = 1; i < 10; i++) begin
      while (cyc < t0 + BIT * i + BIT / 2) cycles(1);
      chk($sformatf("tx bit %0d", i), txd_a, exp_tx[i]);
    end
    while (!rdy_a && cyc - c0 < 2200) cycles(1);
    d = cyc - c0;
    // latch edge + first tick (1..13 clocks) + 10 bits of 208
    chk($sformatf("tx_ready return d=%0d", d), (d >= 2082 && d <= 2094), 1);

    // 7E2 loopback of 0x55
    base = pb;
    data_b = 7'h55; send_b = 1'b1;
    cycles(1);
    send_b = 1'b0;
    k = 0;
    while (!rdy_b && k < 3000) begin cycles(1); k++; end
    chk("loopback tx done", rdy_b, 1);
    cycles(BIT);
    chk("loopback pulses", pb - base, 1);
    chk("loopback data", dout_b, 7'h55);
    chk("loopback frame_err", fe_b, 0);
    chk("loopback parity_err", pe_b, 0);

    // odd-parity receiver fed an even-parity frame, then a correct one
    base = po;
    frame(1, {1'b1, 1'b0, 8'h0F, 1'b0}, 11);
    cycles(BIT);
    chk("odd pulses", po - base, 1);
    chk("odd data", dout_o, 8'h0F);
    chk("odd parity_err set", pe_o, 1);
    chk("odd frame_err", fe_o, 0);
    frame(1, {1'b1, 1'b1, 8'h0F, 1'b0}, 11);
    cycles(BIT);
    chk("odd parity_err clear", pe_o, 0);

    // missing stop bit followed by a 30-bit break, then a clean frame
    base = pa;
    frame(0, {1'b0, 8'h3C, 1'b0}, 10);
    drive(0, 1'b0, 30 * BIT);
    drive(0, 1'b1, 2 * BIT);
    chk("break pulses", pa - base, 1);
    chk("break frame_err", fe_a, 1);
    chk("break data", dout_a, 8'h3C);
    frame(0, {1'b1, 8'h81, 1'b0}, 10);
    cycles(BIT);
    chk("after break pulses", pa - base, 2);
    chk("after break data", dout_a, 8'h81);
    chk("after break frame_err", fe_a, 0);

    // 3-tick start glitch, then a 1-tick glitch in the middle of data bit 3 of 0xFF
    base = pa;
    drive(0, 1'b0, 3 * 13);
    drive(0, 1'b1, 2 * BIT);
    chk("glitch no pulse", pa - base, 0);
    chk("glitch rx idle", u_def.rx_state_q, 0);
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, 3 * BIT + BIT / 2 - 6);
    drive(0, 1'b0, 13);
    drive(0, 1'b1, BIT / 2 - 7 + 5 * BIT);
    chk("data glitch pulses", pa - base, 1);
    chk("data glitch data", dout_a, 8'hFF);
    chk("data glitch frame_err", fe_a, 0);

    // reset in data bit 4 of simultaneous TX (0xE5) and RX (0xC3)
    base = pa;
    rv = 8'hC3;
    data_a = 8'hE5; send_a = 1'b1; rxd_a = 1'b0;
    cycles(1);
    send_a = 1'b0;
    drive(0, 1'b0, BIT - 1);
    for (int i = 0; i < 4; i++) drive(0, rv[i], BIT);
    drive(0, rv[4], BIT / 2);
    chk("tx mid-frame low", txd_a, 0);
    rst = 1'b1; rxd_a = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("abort txd", txd_a, 1);
    chk("abort tx_ready", rdy_a, 1);
    chk("abort data_out cleared", dout_a, 0);
    cycles(3 * BIT);
    chk("abort no pulse", pa - base, 0);
    frame(0, {1'b1, 8'h96, 1'b0}, 10);
    cycles(BIT);
    chk("post-abort pulses", pa - base, 1);
    chk("post-abort data", dout_a, 8'h96);
    chk("post-abort frame_err", fe_a, 0);
    chk("post-abort parity_err", pe_a, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
